wb_initiator: RTL and testbench
===============================

# wb_initiator

Single-outstanding Wishbone classic initiator that turns a valid/ready command stream into Wishbone bus cycles and returns a valid/ready response stream. It is the counterpart of the user-area Wishbone responder. It lets on-chip logic, such as a debug or bring-up controller, issue reads and writes onto a Wishbone segment. It sits between a command source and any Wishbone-classic target sharing the core clock.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (multiple of 8; SEL width = DW/8)
- TIMEOUT_CYCLES, 255, max cycles STB may wait for ACK (≥1); used only when the timeout feature is compiled in

Ports:
- clk  in  1  core clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  AW  byte address
- cmd_dat  in  DW  write data
- cmd_sel  in  DW/8  byte enables
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_dat  out  DW  read data (0 for writes)
- rsp_err  out  1  1 = cycle timed out
- wbm_cyc_o  out  1  Wishbone CYC
- wbm_stb_o  out  1  Wishbone STB
- wbm_we_o  out  1  Wishbone WE
- wbm_adr_o  out  AW  Wishbone ADR
- wbm_dat_o  out  DW  Wishbone write data
- wbm_sel_o  out  DW/8  Wishbone SEL
- wbm_dat_i  in  DW  Wishbone read data
- wbm_ack_i  in  1  Wishbone ACK

## Operation
The FSM has three states: IDLE, BUS and RESP.

- **IDLE**
  - cmd_ready=1.
  - On cmd_valid, register we/adr/dat/sel and go to BUS.
- **BUS**
  - cyc=stb=1; all wbm_* outputs come from registers and are stable for the whole cycle.
  - On wbm_ack_i=1:
    - capture rsp_dat from wbm_dat_i for a read, or 0 for a write;
    - set rsp_err=0;
    - go to RESP.
- **RESP**
  - rsp_valid=1; rsp_dat and rsp_err are held stable.
  - On rsp_ready, go to IDLE.
- **General rules**
  - Only one transaction is ever outstanding.
  - cmd_ready=0 in BUS and RESP.
  - wbm_ack_i is ignored outside BUS.
  - Reset, asynchronous and at any point including mid-cycle: FSM=IDLE, and every output is 0 except cmd_ready. cyc and stb drop immediately with no response.
  - Reset values of outputs:
    - cmd_ready=1 once rst_n is high, because it is decoded from IDLE;
    - rsp_valid, rsp_dat, rsp_err and all wbm_* outputs are 0.

## Timing
- Command accepted at edge N; cyc and stb are high from edge N (registered outputs, visible in cycle N+1).
- ACK sampled high at edge M:
  - cyc and stb are low after edge M;
  - rsp_valid is high after edge M.
  - Zero-wait target: ACK in the first BUS cycle gives a 2-cycle command-to-response latency.
- RESP to IDLE takes one cycle after rsp_ready, so back-to-back commands are spaced ≥3 cycles apart.
- rsp_valid is never withdrawn without rsp_ready.

## Configuration
- WB_INITIATOR_TIMEOUT_EN defined:
  - A cycle counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to BUS and increments each BUS cycle without ACK.
  - When the count reaches TIMEOUT_CYCLES, the initiator drops cyc/stb and goes to RESP with rsp_err=1, rsp_dat=0.
  - ACK and timeout on the same edge: ACK wins and rsp_err=0.
- Not defined:
  - No counter exists and BUS waits indefinitely.
  - rsp_err is tied to 0.

## Structure
- Shared package wb_pkg holds:
  - the state typedef wb_init_state_t (IDLE/BUS/RESP);
  - default AW/DW localparams;
  - the timeout default constant.
- Single module; no sub-module needed. The timeout counter is inline, under the macro.

## Test plan
- **Write, zero-wait:** cmd we=1, adr=0x3000_0004, dat=0xA5A5_1234, sel=0xF; target ACKs in the first cycle.
  - Bus carries exactly those values for 1 cycle.
  - rsp_valid 2 cycles after accept, rsp_dat=0, rsp_err=0.
- **Read with 3 wait states:** target returns 0xDEAD_BEEF with ACK.
  - stb is held 4 cycles.
  - rsp_dat=0xDEAD_BEEF.
  - cmd_ready stays 0 throughout.
- **Response backpressure:** rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_valid and rsp_dat are stable.
  - No new command is accepted until rsp_ready pulses.
- **Timeout (macro on, TIMEOUT_CYCLES=8):** no ACK.
  - cyc drops after 8 BUS cycles.
  - rsp_err=1, rsp_dat=0.
  - Repeat with ACK on the 8th cycle: rsp_err=0.
- **Reset mid-cycle:** rst_n low while stb is high.
  - cyc, stb and rsp_valid go to 0 immediately.
  - cmd_ready=1 after release.
  - A later read completes normally.
- **Stray ACK:** wbm_ack_i pulsed in IDLE and in RESP.
  - No state change.
  - No spurious response.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone initiator definitions: FSM state encoding and default
// bus geometry / timeout values.
package wb_pkg;

  localparam int WB_AW              = 32;
  localparam int WB_DW              = 32;
  localparam int WB_TIMEOUT_CYCLES  = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_init_state_t;

endpackage

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: a valid/ready command is
// turned into one bus cycle, and the result is returned on a valid/ready
// response channel.
//
// Optional build macro: WB_INITIATOR_TIMEOUT_EN adds a bus-cycle watchdog
// that abandons a cycle after TIMEOUT_CYCLES cycles without ACK and reports
// rsp_err=1. Without it the initiator waits for ACK indefinitely and
// rsp_err is tied low.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | cmd_ready high, waiting for a command
// BUS   | cyc/stb asserted from registered command, waiting for ACK
// RESP  | rsp_valid high with captured data, waiting for rsp_ready
module wb_initiator
  import wb_pkg::*;
#(
  parameter int AW             = WB_AW,
  parameter int DW             = WB_DW,
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_dat,
  input  logic [DW/8-1:0] cmd_sel,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb_initiator: TIMEOUT_CYCLES must be at least 1");
  end

  wb_init_state_t state, state_nxt;
  logic           timeout_hit;
  logic           bus_ack;

  // ACK only counts while a cycle is actually on the bus.
  assign bus_ack = (state == BUS) && wbm_ack_i;

`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;

  // Cycle counter: zero outside BUS so it starts clean on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state != BUS) begin
      to_cnt <= '0;
    end else if (!wbm_ack_i) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  // Fires on the edge where the count would reach TIMEOUT_CYCLES; ACK wins.
  assign timeout_hit = (state == BUS) && !wbm_ack_i &&
                       (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Error flag: cleared by a real ACK, set by an abandoned cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else if (bus_ack) begin
      rsp_err <= 1'b0;
    end else if (timeout_hit) begin
      rsp_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/strobe decode from the registered state.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_nxt = BUS;
        end
      end
      BUS: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        if (wbm_ack_i || timeout_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Command capture: bus-side fields stay frozen for the whole cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
    end else if ((state == IDLE) && cmd_valid) begin
      wbm_we_o  <= cmd_we;
      wbm_adr_o <= cmd_adr;
      wbm_dat_o <= cmd_dat;
      wbm_sel_o <= cmd_sel;
    end
  end

  // Response data: read data on ACK, zero for writes and abandoned cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_dat <= '0;
    end else if (bus_ack) begin
      rsp_dat <= wbm_we_o ? '0 : wbm_dat_i;
    end else if (timeout_hit) begin
      rsp_dat <= '0;
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator: table of transactions driven through
// a simple Wishbone target model, responses checked through a scoreboard
// queue, plus hand-written reset and stray-ACK sequences.
module tb_wb_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [DW-1:0] cmd_dat;
  logic [SW-1:0] cmd_sel;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_dat;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic [SW-1:0] wbm_sel_o;
  logic [DW-1:0] wbm_dat_i;
  logic          wbm_ack_i;

  wb_initiator #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i)
  );

  always #5 clk = ~clk;

  // ack_at: BUS cycle (1-based) on which the target ACKs, 0 = never.
  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    int            ack_at;
    logic [DW-1:0] rd;
    int            delay;
    int            exp_stb;
    logic [DW-1:0] exp_dat;
    logic          exp_err;
  } vec_t;

  typedef struct {
    logic [DW-1:0] dat;
    logic          err;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    int            stb_cycles;
    logic [DW-1:0] held_dat;
    rsp_t          exp_r;
    rsp_t          got;
    // present the command; IDLE must be ready
    cmd_we    = v.we;
    cmd_adr   = v.adr;
    cmd_dat   = v.dat;
    cmd_sel   = v.sel;
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    exp_r.dat = v.exp_dat;
    exp_r.err = v.exp_err;
    sb.push_back(exp_r);
    // target model: hold off ACK until ack_at, bounded by a cycle budget
    stb_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      if (!wbm_cyc_o) break;
      stb_cycles++;
      chk("bus_stb", wbm_stb_o, 1'b1);
      chk("bus_we", wbm_we_o, v.we);
      chk("bus_adr", wbm_adr_o, v.adr);
      chk("bus_dat", wbm_dat_o, v.dat);
      chk("bus_sel", wbm_sel_o, v.sel);
      chk("cmd_ready_bus", cmd_ready, 1'b0);
      wbm_ack_i = (stb_cycles == v.ack_at);
      wbm_dat_i = wbm_ack_i ? v.rd : $urandom;
      tick();
      wbm_ack_i = 1'b0;
    end
    chk("stb_cycles", stb_cycles, v.exp_stb);
    chk("stb_low_after", wbm_stb_o, 1'b0);
    chk("rsp_valid_rise", rsp_valid, 1'b1);
    held_dat = rsp_dat;
    // backpressure with a competing command and stray ACKs in RESP
    for (int d = 0; d < v.delay; d++) begin
      cmd_valid = 1'b1;
      cmd_adr   = 32'hBAD0_0000;
      wbm_ack_i = 1'b1;
      wbm_dat_i = $urandom;
      tick();
      chk("rsp_valid_held", rsp_valid, 1'b1);
      chk("rsp_dat_stable", rsp_dat, held_dat);
      chk("no_accept_in_resp", wbm_cyc_o, 1'b0);
      chk("cmd_ready_resp", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    wbm_ack_i = 1'b0;
    rsp_ready = 1'b1;
    if (rsp_valid && sb.size() > 0) begin
      got = sb.pop_front();
      chk("rsp_dat", rsp_dat, got.dat);
      chk("rsp_err", rsp_err, got.err);
    end else begin
      chk("rsp_handshake", {31'd0, rsp_valid}, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 1'b0);
    chk("cmd_ready_back", cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;

    //                we    adr            dat            sel    ack rd             dly stb exp_dat        err
    vecs.push_back('{1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 1, 32'h1111_2222, 0, 1, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h3000_0010, 32'h0000_0000, 4'hF, 4, 32'hDEAD_BEEF, 0, 4, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h3000_0020, 32'h5555_AAAA, 4'h3, 2, 32'h1234_5678, 5, 2, 32'h1234_5678, 1'b0});
    vecs.push_back('{1'b1, 32'h3000_0030, 32'h0F0F_F0F0, 4'h5, 3, 32'h7777_7777, 2, 3, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 4'h1, 1, 32'h0000_00FF, 1, 1, 32'h0000_00FF, 1'b0});
`ifdef WB_INITIATOR_TIMEOUT_EN
    vecs.push_back('{1'b0, 32'h3000_0040, 32'h0000_0000, 4'hF, 0, 32'h9999_9999, 2, TO, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h3000_0044, 32'h0000_0000, 4'hF, TO, 32'hCAFE_F00D, 0, TO, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1'b1, 32'h3000_0048, 32'h1357_9BDF, 4'hC, 0, 32'h9999_9999, 0, TO, 32'h0000_0000, 1'b1});
`endif

    // reset values while rst_n is low
    #12;
    chk("rst_cyc", wbm_cyc_o, 1'b0);
    chk("rst_stb", wbm_stb_o, 1'b0);
    chk("rst_we", wbm_we_o, 1'b0);
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk("rst_dat", wbm_dat_o, 32'h0);
    chk("rst_sel", wbm_sel_o, 4'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_dat", rsp_dat, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    #10;
    rst_n = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    tick();

    // stray ACK while idle
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hDEAD_DEAD;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stray_idle_cyc", wbm_cyc_o, 1'b0);
      chk("stray_idle_rsp", rsp_valid, 1'b0);
      chk("stray_idle_ready", cmd_ready, 1'b1);
    end
    wbm_ack_i = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // reset in the middle of a bus cycle
    cmd_we    = 1'b0;
    cmd_adr   = 32'h3000_0100;
    cmd_sel   = 4'hF;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("midrst_stb_before", wbm_stb_o, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_cyc", wbm_cyc_o, 1'b0);
    chk("midrst_stb", wbm_stb_o, 1'b0);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_adr", wbm_adr_o, 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("midrst_cmd_ready", cmd_ready, 1'b1);
    chk("midrst_no_cyc", wbm_cyc_o, 1'b0);
    @(posedge clk);
    #1;
    chk("midrst_no_rsp", rsp_valid, 1'b0);

    // a normal read after the aborted cycle
    run_txn('{1'b0, 32'h3000_0104, 32'h0, 4'hF, 2, 32'h0BAD_F00D, 1, 2, 32'h0BAD_F00D, 1'b0});

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
